dual_core_scheduler: RTL and testbench

Instruction sequencer for the two-core systolic compute pair. Generates the per-cycle 21-bit instruction words for core 1 and core 2 through the kernel-load / activation-stream / drain loop over all kernel positions. It then enforces a barrier so that both cores assert the partial-sum exchange bit (bit 20) in the same cycle. It sits between the host start/done interface and the instruction inputs of the dual-core wrapper.

---
 rtl/dual_core_scheduler_pkg.sv | 26 ++
 rtl/dual_core_scheduler_core_seq.sv | 118 +++++++++++
 rtl/dual_core_scheduler.sv | 58 +++++
 tb/tb_dual_core_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dual_core_scheduler_pkg.sv
// Shared definitions for the dual-core instruction sequencer: instruction
// field positions, address/counter widths and the per-core state encoding.
package dual_core_scheduler_pkg;

    localparam int INST_W = 21;
    localparam int AW     = 11;
    localparam int CNT_W  = 8;

    localparam int EXCH_B     = 20;
    localparam int ACC_B      = 19;
    localparam int OFIFO_RD_B = 18;
    localparam int ADDR_LSB   = 7;
    localparam int SRAM_WEN_B = 6;
    localparam int SRAM_EN_B  = 5;
    localparam int L0_RD_B    = 4;
    localparam int L0_WR_B    = 3;
    localparam int EXEC_B     = 2;
    localparam int LOAD_B     = 1;

    typedef enum logic [2:0] {
        IDLE, LOAD_W, LOAD_A, DRAIN, SYNC, EXCH, ACCUM, DONE
    } state_t;

    typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/dual_core_scheduler_core_seq.sv
// One core's sequencer: FSM, kij/position counters and instruction encode.
// All outputs are registered, so they trail the FSM state by one cycle.
module core_seq
    import dual_core_scheduler_pkg::*;
#(
    parameter int COL     = 8,
    parameter int PR      = 8,
    parameter int LEN_KIJ = 9,
    parameter int LEN_NIJ = 36,
    parameter int W_BASE  = 0,
    parameter int A_BASE  = 256,
    parameter int P_BASE  = 1024
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    input  logic  peer_sync,
    output logic  in_sync,
    output logic  busy,
    output logic  done,
    output inst_t inst
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] kij;
    inst_t            nxt_inst;
    logic [AW-1:0]    w_addr, a_addr, p_addr;

    assign in_sync = (state == SYNC);

    // Address sums wrap modulo 2^AW by truncation.
    assign w_addr = AW'(W_BASE + int'(kij) * COL + int'(cnt));
    assign a_addr = AW'(A_BASE + int'(cnt));
    assign p_addr = AW'(P_BASE + int'(cnt));

    always_comb begin
        nxt_inst = '0;
        case (state)
            LOAD_W: begin
                nxt_inst[LOAD_B]           = 1'b1;
                nxt_inst[L0_WR_B]          = 1'b1;
                nxt_inst[SRAM_EN_B]        = 1'b1;
                nxt_inst[ADDR_LSB +: AW]   = w_addr;
            end
            LOAD_A: begin
                nxt_inst[EXEC_B]           = 1'b1;
                nxt_inst[L0_WR_B]          = 1'b1;
                nxt_inst[L0_RD_B]          = 1'b1;
                nxt_inst[SRAM_EN_B]        = 1'b1;
                nxt_inst[ADDR_LSB +: AW]   = a_addr;
            end
            EXCH:   nxt_inst[EXCH_B] = 1'b1;
            ACCUM: begin
                nxt_inst[ACC_B]            = 1'b1;
                nxt_inst[OFIFO_RD_B]       = 1'b1;
                nxt_inst[SRAM_EN_B]        = 1'b1;
                nxt_inst[SRAM_WEN_B]       = 1'b1;
                nxt_inst[ADDR_LSB +: AW]   = p_addr;
            end
            default: nxt_inst = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            kij   <= '0;
            inst  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            inst <= nxt_inst;
            busy <= (state != IDLE);
            done <= (state == DONE);
            case (state)
                // busy still reflects DONE on the first IDLE cycle, which
                // keeps a start arriving during the done pulse from launching.
                IDLE: if (start && !busy) begin
                    state <= LOAD_W;
                    cnt   <= '0;
                    kij   <= '0;
                end
                LOAD_W: if (cnt == CNT_W'(COL - 1)) begin
                    cnt   <= '0;
                    state <= LOAD_A;
                end else cnt <= cnt + 1'b1;
                LOAD_A: if (cnt == CNT_W'(LEN_NIJ - 1)) begin
                    cnt   <= '0;
                    state <= DRAIN;
                end else cnt <= cnt + 1'b1;
                DRAIN: if (cnt == CNT_W'(COL + PR - 1)) begin
                    cnt <= '0;
                    if (kij == CNT_W'(LEN_KIJ - 1)) begin
                        kij   <= '0;
                        state <= SYNC;
                    end else begin
                        kij   <= kij + 1'b1;
                        state <= LOAD_W;
                    end
                end else cnt <= cnt + 1'b1;
                SYNC: if (peer_sync) state <= EXCH;
                EXCH: begin
                    cnt   <= '0;
                    state <= ACCUM;
                end
                ACCUM: if (cnt == CNT_W'(LEN_NIJ - 1)) begin
                    cnt   <= '0;
                    state <= DONE;
                end else cnt <= cnt + 1'b1;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dual_core_scheduler.sv
// Two-core instruction sequencer; the cores run independently until both
// reach SYNC, then leave together so the exchange words coincide.
module dual_core_scheduler
    import dual_core_scheduler_pkg::*;
#(
    parameter int COL     = 8,
    parameter int PR      = 8,
    parameter int LEN_KIJ = 9,
    parameter int LEN_NIJ = 36,
    parameter int W_BASE  = 0,
    parameter int A_BASE  = 256,
    parameter int P_BASE  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_core1,
    input  logic              start_core2,
    output logic              busy_core1,
    output logic              busy_core2,
    output logic              done_core1,
    output logic              done_core2,
    output logic [INST_W-1:0] inst_core1,
    output logic [INST_W-1:0] inst_core2
);

    logic in_sync_1, in_sync_2, barrier;

    assign barrier = in_sync_1 & in_sync_2;

    core_seq #(
        .COL(COL), .PR(PR), .LEN_KIJ(LEN_KIJ), .LEN_NIJ(LEN_NIJ),
        .W_BASE(W_BASE), .A_BASE(A_BASE), .P_BASE(P_BASE)
    ) u_core1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start_core1),
        .peer_sync (barrier),
        .in_sync   (in_sync_1),
        .busy      (busy_core1),
        .done      (done_core1),
        .inst      (inst_core1)
    );

    core_seq #(
        .COL(COL), .PR(PR), .LEN_KIJ(LEN_KIJ), .LEN_NIJ(LEN_NIJ),
        .W_BASE(W_BASE), .A_BASE(A_BASE), .P_BASE(P_BASE)
    ) u_core2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start_core2),
        .peer_sync (barrier),
        .in_sync   (in_sync_2),
        .busy      (busy_core2),
        .done      (done_core2),
        .inst      (inst_core2)
    );

endmodule

// File: tb/tb_dual_core_scheduler.sv
// Scoreboard bench for dual_core_scheduler: a spec-derived model queues the
// expected per-cycle words at each accepted start, compared every cycle.
module tb_dual_core_scheduler;

    logic        clk = 1'b0;
    logic        reset, start_core1, start_core2;
    logic        busy_core1, busy_core2, done_core1, done_core2;
    logic [20:0] inst_core1, inst_core2;
    logic        wbusy1, wbusy2, wdone1, wdone2;
    logic [20:0] winst1, winst2;

    always #5 clk = ~clk;

    dual_core_scheduler dut (
        .clk(clk), .reset(reset),
        .start_core1(start_core1), .start_core2(start_core2),
        .busy_core1(busy_core1), .busy_core2(busy_core2),
        .done_core1(done_core1), .done_core2(done_core2),
        .inst_core1(inst_core1), .inst_core2(inst_core2)
    );

    // Second copy with a weight base near the top of the address space.
    dual_core_scheduler #(.W_BASE(2040)) u_wrap (
        .clk(clk), .reset(reset),
        .start_core1(start_core1), .start_core2(start_core2),
        .busy_core1(wbusy1), .busy_core2(wbusy2),
        .done_core1(wdone1), .done_core2(wdone2),
        .inst_core1(winst1), .inst_core2(winst2)
    );

    typedef struct packed {
        logic [20:0] inst;
        logic        busy;
        logic        done;
    } exp_t;

    typedef struct {
        int          off;
        logic [20:0] inst;
    } vec_t;

    typedef struct {
        int d1;
        int d2;
        int rep;
    } scn_t;

    localparam int LDW = 32'h2A;
    localparam int LDA = 32'h3C;
    localparam int ACW = 32'hC0060;
    localparam int EXW = 32'h100000;

    exp_t        q1[$], q2[$], qw[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0, t0 = 0;
    logic [20:0] trace1 [0:8191];

    function automatic logic [20:0] mkw(input int bits, input int addr);
        logic [20:0] w;
        w       = 21'(bits);
        w[17:7] = 11'(addr % 2048);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, expv, cyc);
        end
    endtask

    task automatic push(input int which, input exp_t e);
        case (which)
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: qw.push_back(e);
        endcase
    endtask

    // Expected output stream for one run, led by the idle cycle of start latency.
    task automatic push_run(input int which, input int wbase, input int nsync);
        push(which, '0);
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 8; i++)  push(which, {mkw(LDW, wbase + k * 8 + i), 1'b1, 1'b0});
            for (int n = 0; n < 36; n++) push(which, {mkw(LDA, 256 + n), 1'b1, 1'b0});
            for (int d = 0; d < 16; d++) push(which, {21'd0, 1'b1, 1'b0});
        end
        for (int s = 0; s < nsync; s++) push(which, {21'd0, 1'b1, 1'b0});
        push(which, {mkw(EXW, 0), 1'b1, 1'b0});
        for (int n = 0; n < 36; n++) push(which, {mkw(ACW, 1024 + n), 1'b1, 1'b0});
        push(which, {21'd0, 1'b1, 1'b1});
    endtask

    // One cycle: wait for the falling edge, compare all checked outputs.
    task automatic step();
        exp_t e1, e2, ew;
        @(negedge clk);
        e1 = '0; e2 = '0; ew = '0;
        if (q1.size() > 0) e1 = q1.pop_front();
        if (q2.size() > 0) e2 = q2.pop_front();
        if (qw.size() > 0) ew = qw.pop_front();
        chk("core1", {inst_core1, busy_core1, done_core1}, e1);
        chk("core2", {inst_core2, busy_core2, done_core2}, e2);
        chk("wrap_core1", {winst1, wbusy1, wdone1}, ew);
        if (inst_core1[20] | inst_core2[20])
            chk("exch_pair", 23'({inst_core1[20], inst_core2[20]}), 23'd3);
        if (cyc < 8192) trace1[cyc] = inst_core1;
        cyc++;
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while ((q1.size() + q2.size() + qw.size()) > 0 && k < maxc) begin
            step();
            k++;
        end
        n_cmp++;
        if ((q1.size() + q2.size() + qw.size()) > 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d words still expected after %0d cycles", q1.size() + q2.size() + qw.size(), maxc);
            q1.delete(); q2.delete(); qw.delete();
        end
    endtask

    task automatic run_scn(input int d1, input int d2, input int rep);
        int last, s1, s2;
        last = (d1 > d2) ? d1 : d2;
        s1   = (d2 > d1) ? d2 - d1 + 1 : 1;
        s2   = (d1 > d2) ? d1 - d2 + 1 : 1;
        t0   = cyc;
        for (int t = 0; t <= last; t++) begin
            start_core1 = (t == d1);
            start_core2 = (t == d2);
            if (t == d1) begin
                push_run(1, 0, s1);
                push_run(3, 2040, s1);
            end
            if (t == d2) push_run(2, 0, s2);
            step();
        end
        start_core1 = 1'b0;
        start_core2 = 1'b0;
        if (rep > 0) begin
            repeat (rep - 1) step();
            start_core1 = 1'b1;
            step();
            start_core1 = 1'b0;
        end
        wait_idle(700);
        repeat (4) step();
    endtask

    scn_t scn [4];
    vec_t vt  [12];

    initial begin
        int k;
        scn[0] = '{0, 0, -1};
        scn[1] = '{0, 25, -1};
        scn[2] = '{25, 0, -1};
        scn[3] = '{0, 0, 100};
        vt[0]  = '{1,   mkw(LDW, 0)};
        vt[1]  = '{8,   mkw(LDW, 7)};
        vt[2]  = '{9,   mkw(LDA, 256)};
        vt[3]  = '{44,  mkw(LDA, 291)};
        vt[4]  = '{45,  21'd0};
        vt[5]  = '{61,  mkw(LDW, 8)};
        vt[6]  = '{68,  mkw(LDW, 15)};
        vt[7]  = '{541, 21'd0};
        vt[8]  = '{542, mkw(EXW, 0)};
        vt[9]  = '{543, mkw(ACW, 1024)};
        vt[10] = '{578, mkw(ACW, 1059)};
        vt[11] = '{579, 21'd0};

        reset = 1'b1; start_core1 = 1'b0; start_core2 = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (20) step();

        for (int s = 0; s < 4; s++) begin
            run_scn(scn[s].d1, scn[s].d2, scn[s].rep);
            if (s == 0)
                for (int v = 0; v < 12; v++)
                    chk($sformatf("spot_off%0d", vt[v].off),
                        23'(trace1[t0 + vt[v].off]), 23'(vt[v].inst));
        end

        // Start pulse coincident with the done pulse is ignored.
        start_core1 = 1'b1; start_core2 = 1'b1;
        push_run(1, 0, 1); push_run(2, 0, 1); push_run(3, 2040, 1);
        step();
        start_core1 = 1'b0; start_core2 = 1'b0;
        k = 0;
        while (!done_core1 && k < 700) begin
            step();
            k++;
        end
        chk("done_seen", 23'(done_core1), 23'd1);
        start_core1 = 1'b1;
        step();
        start_core1 = 1'b0;
        wait_idle(10);
        repeat (10) step();

        // Reset during ACCUM aborts at once; a fresh run is then normal.
        start_core1 = 1'b1; start_core2 = 1'b1;
        push_run(1, 0, 1); push_run(2, 0, 1); push_run(3, 2040, 1);
        step();
        start_core1 = 1'b0; start_core2 = 1'b0;
        repeat (559) step();
        reset = 1'b1;
        q1.delete(); q2.delete(); qw.delete();
        step();
        reset = 1'b0;
        repeat (3) step();
        run_scn(0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
